// File: rtl/lag_stats_bcd_if.sv
// Bus bundle between the lag measurement source and the lag statistics block:
// sample/control strobes in one direction, status and packed BCD word back.
interface lag_stats_bcd_if #(
  parameter int LAG_W = 24
);
  logic             lag_valid;
  logic [LAG_W-1:0] lag_value;
  logic             clear;
  logic             frame_start;
  logic             busy;
  logic             overrun;
  logic [79:0]      bcdcount;

  modport master (
    output lag_valid, lag_value, clear, frame_start,
    input  busy, overrun, bcdcount
  );

  modport slave (
    input  lag_valid, lag_value, clear, frame_start,
    output busy, overrun, bcdcount
  );
endinterface

// File: rtl/lag_stats_bcd.sv
// Lag statistics: tracks current/min/max/block-average lag, converts each to
// 5 BCD digits with a bit-serial double-dabble, and publishes the 80-bit word
// only on a frame-start strobe so the rendered text never tears.
module lag_stats_bcd #(
  parameter int LAG_W    = 24,
  parameter int AVG_LOG2 = 4
) (
  input  logic              clock,
  input  logic              reset,
  lag_stats_bcd_if.slave    bus
);

  localparam int SUM_W = 17 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [79:0]      RESET_WORD = 80'h99999_00000_99999_99999;
  localparam logic [19:0]      NO_VALUE   = 20'h99999;
  localparam logic [LAG_W-1:0] CLAMP_MAX  = LAG_W'(99998);

  typedef enum logic [1:0] {IDLE, UPDATE, CONV} state_t;

  state_t state_reg, state_next;

  logic [16:0]      v_clamped;
  logic [16:0]      v_reg;
  logic [16:0]      cur_reg, min_reg, max_reg, avg_reg;
  logic [SUM_W-1:0] sum_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             have_sample_reg, have_avg_reg;

  logic [4:0]       step_reg;
  logic [1:0]       field_reg;
  logic [16:0]      bin_reg;
  logic [19:0]      bcd_reg;
  logic [59:0]      work_reg;
  logic [79:0]      staging_reg;
  logic             pending_reg;
  logic             overrun_reg;
  logic [79:0]      bcdcount_reg;

  logic             busy;
  logic             accept;
  logic             conv_last;
  logic [SUM_W-1:0] sum_add;
  logic [CNT_W-1:0] cnt_inc;
  logic [16:0]      field_val;
  logic [16:0]      bin_src;
  logic [19:0]      bcd_src;
  logic [18:0]      bcd_adj;
  logic [19:0]      bcd_new;
  logic [19:0]      avg_bcd;

  // 99999 is reserved as the "no value" sentinel, so saturate one below it
  assign v_clamped = (bus.lag_value > CLAMP_MAX) ? 17'd99998 : bus.lag_value[16:0];

  assign busy    = (state_reg != IDLE);
  assign sum_add = sum_reg + SUM_W'(v_reg);
  assign cnt_inc = cnt_reg + CNT_W'(1);

  // Binary source for the field being converted, in display order
  always_comb begin
    field_val = cur_reg;
    case (field_reg)
      2'd0:    field_val = cur_reg;
      2'd1:    field_val = min_reg;
      2'd2:    field_val = max_reg;
      default: field_val = avg_reg;
    endcase
  end

  // First step of each field starts from the fresh binary value and zero BCD
  assign bin_src = (step_reg == 5'd0) ? field_val : bin_reg;
  assign bcd_src = (step_reg == 5'd0) ? 20'h00000 : bcd_reg;

  // Add-3 correction per digit; the top digit only needs 3 bits because the
  // result never exceeds 99999, so its carry-out is never shifted in
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_add3
      if (gi < 4) begin : g_full
        assign bcd_adj[gi*4 +: 4] = (bcd_src[gi*4 +: 4] >= 4'd5) ?
                                    bcd_src[gi*4 +: 4] + 4'd3 : bcd_src[gi*4 +: 4];
      end else begin : g_top
        assign bcd_adj[18:16] = bcd_src[18:16] +
                                ((bcd_src[19:16] >= 4'd5) ? 3'd3 : 3'd0);
      end
    end
  endgenerate

  assign bcd_new = {bcd_adj, bin_src[16]};
  assign avg_bcd = have_avg_reg ? bcd_new : NO_VALUE;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and control decode
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    conv_last  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.lag_valid) begin
          accept     = 1'b1;
          state_next = UPDATE;
        end
      end
      UPDATE: state_next = CONV;
      CONV: begin
        if (field_reg == 2'd3 && step_reg == 5'd16) begin
          conv_last  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (bus.clear) begin
      state_next = IDLE;
      accept     = 1'b0;
      conv_last  = 1'b0;
    end
  end

  // Statistics, conversion datapath, staging and frame-synchronous commit
  always_ff @(posedge clock) begin
    if (reset) begin
      v_reg           <= '0;
      cur_reg         <= '0;
      min_reg         <= '0;
      max_reg         <= '0;
      avg_reg         <= '0;
      sum_reg         <= '0;
      cnt_reg         <= '0;
      have_sample_reg <= 1'b0;
      have_avg_reg    <= 1'b0;
      step_reg        <= '0;
      field_reg       <= '0;
      bin_reg         <= '0;
      bcd_reg         <= '0;
      work_reg        <= '0;
      staging_reg     <= RESET_WORD;
      pending_reg     <= 1'b0;
      overrun_reg     <= 1'b0;
      bcdcount_reg    <= RESET_WORD;
    end else if (bus.clear) begin
      sum_reg         <= '0;
      cnt_reg         <= '0;
      have_sample_reg <= 1'b0;
      have_avg_reg    <= 1'b0;
      step_reg        <= '0;
      field_reg       <= '0;
      staging_reg     <= RESET_WORD;
      pending_reg     <= 1'b1;
      overrun_reg     <= 1'b0;
    end else begin
      if (bus.lag_valid && busy) overrun_reg <= 1'b1;
      if (accept) v_reg <= v_clamped;

      if (state_reg == UPDATE) begin
        cur_reg         <= v_reg;
        min_reg         <= (have_sample_reg && min_reg < v_reg) ? min_reg : v_reg;
        max_reg         <= (have_sample_reg && max_reg > v_reg) ? max_reg : v_reg;
        have_sample_reg <= 1'b1;
        if (cnt_inc[AVG_LOG2]) begin
          avg_reg      <= sum_add[SUM_W-1:AVG_LOG2];
          have_avg_reg <= 1'b1;
          sum_reg      <= '0;
          cnt_reg      <= '0;
        end else begin
          sum_reg <= sum_add;
          cnt_reg <= cnt_inc;
        end
        step_reg  <= '0;
        field_reg <= '0;
      end

      if (state_reg == CONV) begin
        bin_reg <= {bin_src[15:0], 1'b0};
        bcd_reg <= bcd_new;
        if (step_reg == 5'd16) begin
          case (field_reg)
            2'd0:    work_reg[19:0]  <= bcd_new;
            2'd1:    work_reg[39:20] <= bcd_new;
            2'd2:    work_reg[59:40] <= bcd_new;
            default: ;
          endcase
          step_reg  <= '0;
          field_reg <= field_reg + 2'd1;
        end else begin
          step_reg <= step_reg + 5'd1;
        end
      end

      if (bus.frame_start && pending_reg) begin
        bcdcount_reg <= staging_reg;
        pending_reg  <= 1'b0;
      end

      // A conversion finishing on this edge re-arms pending after any commit
      if (conv_last) begin
        staging_reg <= {avg_bcd, work_reg};
        pending_reg <= 1'b1;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.overrun  = overrun_reg;
  assign bus.bcdcount = bcdcount_reg;

endmodule

// File: tb/tb_lag_stats_bcd.sv
// Directed bench for lag_stats_bcd: a vector table for the average block plus
// hand-written sequences for latency, clamp/overrun, clear and commit timing.
module tb_lag_stats_bcd;

  localparam logic [79:0] RESET_WORD = 80'h99999_00000_99999_99999;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  lag_stats_bcd_if #(.LAG_W(24)) bus ();

  lag_stats_bcd #(.LAG_W(24), .AVG_LOG2(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [23:0] lag;
    bit          commit;
    logic [79:0] exp;
  } vec_t;

  vec_t tbl [17];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic send(input logic [23:0] v);
    bus.lag_value = v;
    bus.lag_valid = 1'b1;
    tick();
    bus.lag_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    int hi;
    bus.lag_valid   = 1'b0;
    bus.lag_value   = '0;
    bus.clear       = 1'b0;
    bus.frame_start = 1'b0;

    // Average block after a clear: 100..115, then 500
    for (int i = 0; i < 16; i++) begin
      tbl[i].lag    = 24'(100 + i);
      tbl[i].commit = 1'b0;
      tbl[i].exp    = '0;
    end
    tbl[7].commit  = 1'b1;
    tbl[7].exp     = 80'h99999_00107_00100_00107;
    tbl[15].commit = 1'b1;
    tbl[15].exp    = 80'h00107_00115_00100_00115;
    tbl[16].lag    = 24'd500;
    tbl[16].commit = 1'b1;
    tbl[16].exp    = 80'h00107_00500_00100_00500;

    // Reset
    tick();
    tick();
    reset = 1'b0;
    check("reset_bcdcount", bus.bcdcount, RESET_WORD);
    check("reset_busy", 80'(bus.busy), 80'd0);
    check("reset_overrun", 80'(bus.overrun), 80'd0);

    // One sample: busy window, early frame_start, then commit
    send(24'd1234);
    hi = 0;
    while (bus.busy && hi < 200) begin
      hi++;
      if (hi == 69) bus.frame_start = 1'b1;
      tick();
    end
    check("busy_cycles", 80'(hi), 80'd69);
    check("no_commit_T69", bus.bcdcount, RESET_WORD);
    tick();
    bus.frame_start = 1'b0;
    check("commit_T70", bus.bcdcount, 80'h99999_01234_01234_01234);

    pulse_clear();
    frame();
    check("clear_blanks", bus.bcdcount, RESET_WORD);

    // Table-driven average block
    for (int i = 0; i < 17; i++) begin
      send(tbl[i].lag);
      wait_idle();
      if (tbl[i].commit) begin
        frame();
        check($sformatf("avg_vec%0d", i), bus.bcdcount, tbl[i].exp);
      end
    end

    // Clamp and overrun
    pulse_clear();
    frame();
    send(24'd200000);
    for (int i = 0; i < 9; i++) tick();
    send(24'd5);
    check("overrun_set", 80'(bus.overrun), 80'd1);
    wait_idle();
    frame();
    check("clamp_word", bus.bcdcount, 80'h99999_99998_99998_99998);

    // Clear mid-conversion, with a simultaneous lag_valid that must be ignored
    send(24'd777);
    for (int i = 0; i < 29; i++) tick();
    bus.clear     = 1'b1;
    bus.lag_valid = 1'b1;
    bus.lag_value = 24'd9;
    tick();
    bus.clear     = 1'b0;
    bus.lag_valid = 1'b0;
    check("clear_busy", 80'(bus.busy), 80'd0);
    check("clear_overrun", 80'(bus.overrun), 80'd0);
    tick();
    tick();
    check("clear_ignores_valid", 80'(bus.busy), 80'd0);
    frame();
    check("clear_commit", bus.bcdcount, RESET_WORD);
    send(24'd42);
    wait_idle();
    frame();
    check("after_clear_42", bus.bcdcount, 80'h99999_00042_00042_00042);

    // No tearing: frame without pending holds; only last sample is committed
    frame();
    check("hold_no_pending", bus.bcdcount, 80'h99999_00042_00042_00042);
    send(24'd300);
    wait_idle();
    send(24'd10);
    wait_idle();
    check("hold_between_frames", bus.bcdcount, 80'h99999_00042_00042_00042);
    send(24'd55);
    wait_idle();
    frame();
    check("latest_commit", bus.bcdcount, 80'h99999_00300_00010_00055);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
